clock_gen: RTL and testbench

- Synthesizable clock generator that derives the processor's pipeline clock from a reference clock by integer division.
- Output period is PERIOD reference cycles (default 10), with near-50% duty.
- Provides a glitch-free stop/start, one-cycle edge strobes, a period change applied only at a period boundary, and a count of generated rising edges.
- Sits at the top of the processor; every pipeline stage is clocked from clk_out.

---
 rtl/clock_pkg.sv | 12 +
 rtl/clock_gen_period_reg.sv | 52 +++++
 rtl/clock_gen.sv | 116 +++++++++++
 tb/tb_clock_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants and the period clamp used by the clock generator and its period register.
package clock_pkg;

    localparam int DEFAULT_PERIOD = 10;
    localparam int MIN_PERIOD     = 2;

    // Anything shorter than two reference cycles cannot have both a high and a low phase.
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : p;
    endfunction

endpackage

// File: rtl/clock_gen_period_reg.sv
// Holds a pending period request and promotes it to the active period when told to apply.
module clock_gen_period_reg
    import clock_pkg::*;
#(
    parameter int PERIOD = DEFAULT_PERIOD,
    parameter int W      = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         per_load,
    input  logic [W-1:0] per_val,
    input  logic         apply,
    output logic [W-1:0] per_cur,
    output logic [W-1:0] per_next
);

    localparam logic [W-1:0] RESET_PERIOD = W'(clamp_period(32'(PERIOD)));

    logic [W-1:0] per_cur_q;
    logic [W-1:0] pend_q;
    logic         pend_valid_q;
    logic [W-1:0] load_val;

    assign load_val = W'(clamp_period(32'(per_val)));

    // A load arriving on the applying edge wins, so it governs the period that starts there.
    always_comb begin
        per_next = per_cur_q;
        if (per_load) begin
            per_next = load_val;
        end else if (pend_valid_q) begin
            per_next = pend_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_cur_q    <= RESET_PERIOD;
            pend_q       <= RESET_PERIOD;
            pend_valid_q <= 1'b0;
        end else if (apply) begin
            per_cur_q    <= per_next;
            pend_valid_q <= 1'b0;
        end else if (per_load) begin
            pend_q       <= load_val;
            pend_valid_q <= 1'b1;
        end
    end

    assign per_cur = per_cur_q;

endmodule

// File: rtl/clock_gen.sv
// Integer-divide clock generator: registered clk_out with edge strobes, clean stop/start
// at period boundaries, deferred period changes and a rising-edge counter.
module clock_gen
    import clock_pkg::*;
#(
    parameter int PERIOD = DEFAULT_PERIOD,
    parameter int W      = 16,
    parameter int CW     = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          per_load,
    input  logic [W-1:0]  per_val,
    output logic          clk_out,
    output logic          rise_stb,
    output logic          fall_stb,
    output logic          running,
    output logic [W-1:0]  per_cur,
    output logic [CW-1:0] cyc_cnt
);

    localparam logic [0:0]   STOPPED      = 1'b0;
    localparam logic [0:0]   RUNNING      = 1'b1;
    localparam logic [W-1:0] RESET_PERIOD = W'(clamp_period(32'(PERIOD)));

    logic [0:0]    state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic          clk_out_q, clk_out_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cyc_q, cyc_d;

    logic [W-1:0]  per_next;
    logic          apply;
    logic [W-1:0]  nxt;
    logic [W:0]    hi;
    logic          at_end;

    clock_gen_period_reg #(
        .PERIOD (PERIOD),
        .W      (W)
    ) u_period_reg (
        .clk      (clk),
        .reset    (reset),
        .per_load (per_load),
        .per_val  (per_val),
        .apply    (apply),
        .per_cur  (per_cur),
        .per_next (per_next)
    );

    always_comb begin
        hi     = ({1'b0, per_cur} + (W+1)'(1)) >> 1;
        at_end = (cnt_q == per_cur - W'(1));
        nxt    = at_end ? '0 : cnt_q + W'(1);

        state_d   = state_q;
        cnt_d     = cnt_q;
        clk_out_d = 1'b0;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        cyc_d     = cyc_q;
        apply     = 1'b0;

        if (state_q == STOPPED) begin
            // While stopped the pending period is adopted at once; starting begins a fresh period.
            apply = 1'b1;
            if (en) begin
                state_d   = RUNNING;
                cnt_d     = '0;
                clk_out_d = 1'b1;
                rise_d    = 1'b1;
                cyc_d     = cyc_q + CW'(1);
            end else begin
                cnt_d = per_next - W'(1);
            end
        end else if (at_end && !en) begin
            state_d = STOPPED;
        end else begin
            apply     = at_end;
            cnt_d     = nxt;
            clk_out_d = ({1'b0, nxt} < hi);
            rise_d    = at_end;
            fall_d    = ({1'b0, nxt} == hi);
            if (at_end) begin
                cyc_d = cyc_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= STOPPED;
            cnt_q     <= RESET_PERIOD - W'(1);
            clk_out_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            cyc_q     <= cyc_d;
        end
    end

    assign clk_out  = clk_out_q;
    assign rise_stb = rise_q;
    assign fall_stb = fall_q;
    assign running  = (state_q == RUNNING);
    assign cyc_cnt  = cyc_q;

endmodule

// File: tb/tb_clock_gen.sv
// Directed scenario bench for clock_gen: waveform shape, stop/start, period changes, resets.
module tb_clock_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic        per_load;
    logic [15:0] per_val;
    logic        clk_out;
    logic        rise_stb;
    logic        fall_stb;
    logic        running;
    logic [15:0] per_cur;
    logic [31:0] cyc_cnt;

    int n_cmp;
    int n_bad;

    clock_gen #(
        .PERIOD (10),
        .W      (16),
        .CW     (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .per_load (per_load),
        .per_val  (per_val),
        .clk_out  (clk_out),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .running  (running),
        .per_cur  (per_cur),
        .cyc_cnt  (cyc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        reset = 1'b0; en = 1'b0; per_load = 1'b0; per_val = '0;
        repeat (3) step();
        got = {clk_out, rise_stb, fall_stb, running};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_bad++; $display("FAIL reset_outputs: got %b expected 0000", got);
        end
        n_cmp++;
        if (cyc_cnt !== 32'd0) begin
            n_bad++; $display("FAIL reset_cyc_cnt: got %0d expected 0", cyc_cnt);
        end
        n_cmp++;
        if (per_cur !== 16'd10) begin
            n_bad++; $display("FAIL reset_per_cur: got %0d expected 10", per_cur);
        end
        $display("test_reset done");
    endtask

    // Period 10: phases 0-4 high, fall strobe at phase 5.
    task automatic test_start_p10();
        logic [3:0] got, exp;
        int ph;
        en = 1'b1; reset = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            ph  = (k - 1) % 10;
            got = {clk_out, rise_stb, fall_stb, running};
            exp = {ph < 5, ph == 0, ph == 5, 1'b1};
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("FAIL p10_wave k=%0d: got %b expected %b", k, got, exp);
            end
        end
        n_cmp++;
        if (cyc_cnt !== 32'd3) begin
            n_bad++; $display("FAIL p10_cyc_cnt: got %0d expected 3", cyc_cnt);
        end
        $display("test_start_p10 done");
    endtask

    // Load issued on the wrap edge governs the very next period: 4 high / 3 low.
    task automatic test_period7();
        logic [3:0] got, exp;
        int ph;
        for (int k = 1; k <= 14; k++) begin
            if (k == 1) begin per_load = 1'b1; per_val = 16'd7; end
            step();
            per_load = 1'b0;
            ph  = (k - 1) % 7;
            got = {clk_out, rise_stb, fall_stb, running};
            exp = {ph < 4, ph == 0, ph == 4, 1'b1};
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("FAIL p7_wave k=%0d: got %b expected %b", k, got, exp);
            end
            n_cmp++;
            if (per_cur !== 16'd7) begin
                n_bad++; $display("FAIL p7_per_cur k=%0d: got %0d expected 7", k, per_cur);
            end
        end
        $display("test_period7 done");
    endtask

    task automatic test_stop();
        logic [3:0] got, exp;
        int ph;
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) begin per_load = 1'b1; per_val = 16'd10; end
            if (k == 3) en = 1'b0;
            step();
            per_load = 1'b0;
            ph  = k - 1;
            got = {clk_out, rise_stb, fall_stb, running};
            exp = {ph < 5, ph == 0, ph == 5, 1'b1};
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("FAIL stop_drain k=%0d: got %b expected %b", k, got, exp);
            end
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            got = {clk_out, rise_stb, fall_stb, running};
            n_cmp++;
            if (got !== 4'b0000) begin
                n_bad++; $display("FAIL stop_idle k=%0d: got %b expected 0000", k, got);
            end
        end
        en = 1'b1;
        step();
        got = {clk_out, rise_stb, fall_stb, running};
        n_cmp++;
        if (got !== 4'b1101) begin
            n_bad++; $display("FAIL stop_restart: got %b expected 1101", got);
        end
        $display("test_stop done");
    endtask

    task automatic test_per_change();
        logic [3:0] got, exp;
        int ph;
        // Finish the current 10-cycle period with a load of 4 arriving mid-period.
        for (int k = 2; k <= 10; k++) begin
            if (k == 3) begin per_load = 1'b1; per_val = 16'd4; end
            step();
            per_load = 1'b0;
            ph  = k - 1;
            got = {clk_out, rise_stb, fall_stb, running};
            exp = {ph < 5, ph == 0, ph == 5, 1'b1};
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("FAIL chg_p10 k=%0d: got %b expected %b", k, got, exp);
            end
            n_cmp++;
            if (per_cur !== 16'd10) begin
                n_bad++; $display("FAIL chg_p10_per k=%0d: got %0d expected 10", k, per_cur);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            if (k == 6) begin per_load = 1'b1; per_val = 16'd1; end
            step();
            per_load = 1'b0;
            ph  = (k - 1) % 4;
            got = {clk_out, rise_stb, fall_stb, running};
            exp = {ph < 2, ph == 0, ph == 2, 1'b1};
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("FAIL chg_p4 k=%0d: got %b expected %b", k, got, exp);
            end
            n_cmp++;
            if (per_cur !== 16'd4) begin
                n_bad++; $display("FAIL chg_p4_per k=%0d: got %0d expected 4", k, per_cur);
            end
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            ph  = (k - 1) % 2;
            got = {clk_out, rise_stb, fall_stb, running};
            exp = {ph < 1, ph == 0, ph == 1, 1'b1};
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("FAIL chg_p2 k=%0d: got %b expected %b", k, got, exp);
            end
            n_cmp++;
            if (per_cur !== 16'd2) begin
                n_bad++; $display("FAIL chg_p2_per k=%0d: got %0d expected 2", k, per_cur);
            end
        end
        $display("test_per_change done");
    endtask

    task automatic test_async_reset();
        logic [3:0] got, exp;
        int ph;
        step();
        n_cmp++;
        if (clk_out !== 1'b1) begin
            n_bad++; $display("FAIL areset_pre_high: got %b expected 1", clk_out);
        end
        #2 reset = 1'b0;
        #1;
        got = {clk_out, rise_stb, fall_stb, running};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_bad++; $display("FAIL areset_immediate: got %b expected 0000", got);
        end
        n_cmp++;
        if (cyc_cnt !== 32'd0) begin
            n_bad++; $display("FAIL areset_cyc_cnt: got %0d expected 0", cyc_cnt);
        end
        n_cmp++;
        if (per_cur !== 16'd10) begin
            n_bad++; $display("FAIL areset_per_cur: got %0d expected 10", per_cur);
        end
        step();
        got = {clk_out, rise_stb, fall_stb, running};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_bad++; $display("FAIL areset_held: got %b expected 0000", got);
        end
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            ph  = k - 1;
            got = {clk_out, rise_stb, fall_stb, running};
            exp = {ph < 5, ph == 0, ph == 5, 1'b1};
            n_cmp++;
            if (got !== exp) begin
                n_bad++; $display("FAIL areset_restart k=%0d: got %b expected %b", k, got, exp);
            end
        end
        n_cmp++;
        if (cyc_cnt !== 32'd1) begin
            n_bad++; $display("FAIL areset_restart_cyc: got %0d expected 1", cyc_cnt);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_idle_en0();
        logic [3:0] got;
        en = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            got = {clk_out, rise_stb, fall_stb, running};
            n_cmp++;
            if (got !== 4'b0000 || cyc_cnt !== 32'd0) begin
                n_bad++;
                $display("FAIL idle_en0 k=%0d: got %b cyc %0d expected 0000 cyc 0", k, got, cyc_cnt);
            end
        end
        $display("test_idle_en0 done");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_start_p10();
        test_period7();
        test_stop();
        test_per_change();
        test_async_reset();
        test_idle_en0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
